// File: rtl/piso_multilane.sv
// Multi-lane parallel-in/serial-out serialiser: a WIDTH-bit word is accepted over valid/ready
// and sent as LANES-bit beats with first/last framing, followed by EXTRA_BITS idle cycles.
module piso_multilane #(
    parameter int unsigned WIDTH      = 42,
    parameter int unsigned LANES      = 2,
    parameter int unsigned EXTRA_BITS = 3,
    parameter bit          MSB_FIRST  = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic [LANES-1:0] sdata,
    output logic             sframe,
    output logic             sfirst,
    output logic             slast,
    output logic             busy
);

    localparam int unsigned BEATS    = (WIDTH + LANES - 1) / LANES;
    localparam int unsigned PW       = BEATS * LANES;
    localparam int unsigned BW       = $clog2(BEATS + 1);
    localparam int unsigned GW       = (EXTRA_BITS > 0) ? $clog2(EXTRA_BITS + 1) : 1;
    localparam int unsigned GAP_LAST = (EXTRA_BITS > 0) ? EXTRA_BITS - 1 : 0;
    localparam bit          NO_GAP   = (EXTRA_BITS == 0);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_GAP   = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [BW-1:0]    beat_q, beat_d;
    logic [GW-1:0]    gap_q, gap_d;
    logic [PW-1:0]    sr_q, sr_d;
    logic [LANES-1:0] sdata_q, sdata_d;
    logic             sframe_q, sframe_d;
    logic             sfirst_q, sfirst_d;
    logic             slast_q, slast_d;
    logic             busy_q, busy_d;

    logic last_beat_c;
    logic last_gap_c;
    logic accept_c;

    // Chunk presented on the current beat: low end for LSB-first, high end for MSB-first.
    function automatic logic [LANES-1:0] head(input logic [PW-1:0] v);
        if (MSB_FIRST) begin
            return v[PW-1 -: LANES];
        end
        return v[LANES-1:0];
    endfunction

    function automatic logic [PW-1:0] advance(input logic [PW-1:0] v);
        if (MSB_FIRST) begin
            return v << LANES;
        end
        return v >> LANES;
    endfunction

    assign last_beat_c = (state_q == S_SHIFT) && (beat_q == BW'(BEATS - 1));
    assign last_gap_c  = (state_q == S_GAP) && (gap_q == GW'(GAP_LAST));
    assign din_ready   = !rst && ((state_q == S_IDLE)
                                  || (last_beat_c && NO_GAP)
                                  || last_gap_c);
    assign accept_c    = din_valid && din_ready;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (accept_c) begin
                    state_d = S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (last_beat_c) begin
                    if (!NO_GAP) begin
                        state_d = S_GAP;
                    end else if (accept_c) begin
                        state_d = S_SHIFT;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            S_GAP: begin
                if (last_gap_c) begin
                    state_d = accept_c ? S_SHIFT : S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath and registered output values, derived from the state being entered
    always_comb begin
        sr_d     = sr_q;
        beat_d   = '0;
        gap_d    = '0;
        sdata_d  = '0;
        sframe_d = 1'b0;
        sfirst_d = 1'b0;
        slast_d  = 1'b0;
        busy_d   = (state_d != S_IDLE);

        if (accept_c) begin
            sr_d = PW'(din);
        end else if (state_q == S_SHIFT && !last_beat_c) begin
            sr_d   = advance(sr_q);
            beat_d = beat_q + BW'(1);
        end else if (last_beat_c) begin
            sr_d = '0;
        end

        if (state_q == S_GAP && !last_gap_c) begin
            gap_d = gap_q + GW'(1);
        end

        if (state_d == S_SHIFT) begin
            sdata_d  = head(sr_d);
            sframe_d = 1'b1;
            sfirst_d = (beat_d == '0);
            slast_d  = (beat_d == BW'(BEATS - 1));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            beat_q   <= '0;
            gap_q    <= '0;
            sr_q     <= '0;
            sdata_q  <= '0;
            sframe_q <= 1'b0;
            sfirst_q <= 1'b0;
            slast_q  <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            beat_q   <= beat_d;
            gap_q    <= gap_d;
            sr_q     <= sr_d;
            sdata_q  <= sdata_d;
            sframe_q <= sframe_d;
            sfirst_q <= sfirst_d;
            slast_q  <= slast_d;
            busy_q   <= busy_d;
        end
    end

    assign sdata  = sdata_q;
    assign sframe = sframe_q;
    assign sfirst = sfirst_q;
    assign slast  = slast_q;
    assign busy   = busy_q;

endmodule
